// File: rtl/cmd_frame_receiver.sv
// Validates the 4-byte UDP state-command frame (sync, cmd, seq, xor), strobes accepted
// commands, holds the working mode and drives the ack handshake. Optional: CMD_DUP_FILTER_EN.
module cmd_frame_receiver #(
    parameter logic [7:0]  SYNC_BYTE      = 8'h5A,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned TO_W           = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       rx_en,
    input  logic [7:0] rx_data,
    input  logic       rx_pkt_done,
    output logic [1:0] cmd_out,
    output logic       cmd_valid,
    output logic [7:0] cmd_seq,
    output logic       mode_power,
    output logic       mode_save,
    output logic       mode_fetch,
    output logic       ack_req,
    input  logic       ack_done,
    output logic       frame_err,
    output logic [7:0] err_cnt
);

    typedef enum logic [2:0] {
        IDLE, GOT_SYNC, GOT_CMD, GOT_SEQ, CHECKED, DROP
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      xor_q, xor_d;
    logic [1:0]      cmd_tmp_q, cmd_tmp_d;
    logic [7:0]      seq_tmp_q, seq_tmp_d;
    logic            ok_q, ok_d;
    logic            bad_q, bad_d;
    logic            silent_q, silent_d;
    logic            armed_q, armed_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [1:0]      cmd_out_q, cmd_out_d;
    logic [7:0]      cmd_seq_q, cmd_seq_d;
    logic [2:0]      mode_q, mode_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic            ack_req_q, ack_req_d;
    logic            frame_err_q, frame_err_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic            in_frame_c, good_c, err_c, dup_c;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            xor_q       <= '0;
            cmd_tmp_q   <= '0;
            seq_tmp_q   <= '0;
            ok_q        <= 1'b0;
            bad_q       <= 1'b0;
            silent_q    <= 1'b0;
            armed_q     <= 1'b0;
            to_cnt_q    <= '0;
            cmd_out_q   <= '0;
            cmd_seq_q   <= '0;
            mode_q      <= '0;
            cmd_valid_q <= 1'b0;
            ack_req_q   <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            xor_q       <= xor_d;
            cmd_tmp_q   <= cmd_tmp_d;
            seq_tmp_q   <= seq_tmp_d;
            ok_q        <= ok_d;
            bad_q       <= bad_d;
            silent_q    <= silent_d;
            armed_q     <= armed_d;
            to_cnt_q    <= to_cnt_d;
            cmd_out_q   <= cmd_out_d;
            cmd_seq_q   <= cmd_seq_d;
            mode_q      <= mode_d;
            cmd_valid_q <= cmd_valid_d;
            ack_req_q   <= ack_req_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        xor_d       = xor_q;
        cmd_tmp_d   = cmd_tmp_q;
        seq_tmp_d   = seq_tmp_q;
        ok_d        = ok_q;
        bad_d       = bad_q;
        silent_d    = silent_q;
        armed_d     = armed_q;
        to_cnt_d    = '0;
        cmd_out_d   = cmd_out_q;
        cmd_seq_d   = cmd_seq_q;
        mode_d      = mode_q;
        cmd_valid_d = 1'b0;
        ack_req_d   = ack_req_q;
        frame_err_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        good_c      = 1'b0;
        err_c       = 1'b0;
        dup_c       = 1'b0;
        in_frame_c  = (state_q == GOT_SYNC) || (state_q == GOT_CMD) ||
                      (state_q == GOT_SEQ)  || (state_q == CHECKED);

        if (ack_done) ack_req_d = 1'b0;

        // Byte consumption happens before any same-cycle packet-end evaluation
        if (rx_en) begin
            case (state_q)
                IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d = GOT_SYNC;
                        xor_d   = rx_data;
                        ok_d    = 1'b0;
                        bad_d   = 1'b0;
                    end else begin
                        state_d = DROP;
                    end
                end
                GOT_SYNC: begin
                    cmd_tmp_d = rx_data[1:0];
                    if (rx_data[7:2] != 6'd0) bad_d = 1'b1;
                    xor_d   = xor_q ^ rx_data;
                    state_d = GOT_CMD;
                end
                GOT_CMD: begin
                    seq_tmp_d = rx_data;
                    xor_d     = xor_q ^ rx_data;
                    state_d   = GOT_SEQ;
                end
                GOT_SEQ: begin
                    ok_d    = (rx_data == xor_q);
                    state_d = CHECKED;
                end
                CHECKED: bad_d = 1'b1;
                default: ;
            endcase
        end else if (in_frame_c) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end

        if (rx_pkt_done) begin
            if (state_d == CHECKED && ok_d && !bad_d)
                good_c = 1'b1;
            else if (state_d != IDLE && !(state_d == DROP && silent_d))
                err_c = 1'b1;
            state_d  = IDLE;
            silent_d = 1'b0;
            to_cnt_d = '0;
        end else if (in_frame_c && !rx_en && to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            // Timed-out frame is counted now; its later packet end must stay silent
            err_c    = 1'b1;
            state_d  = DROP;
            silent_d = 1'b1;
            to_cnt_d = '0;
        end

`ifdef CMD_DUP_FILTER_EN
        dup_c = armed_q && (seq_tmp_d == cmd_seq_q);
`endif

        if (good_c) begin
            ack_req_d = 1'b1;
            if (!dup_c) begin
                armed_d     = 1'b1;
                cmd_valid_d = 1'b1;
                cmd_out_d   = cmd_tmp_d;
                cmd_seq_d   = seq_tmp_d;
                case (cmd_tmp_d)
                    2'b01:   mode_d = 3'b001;
                    2'b10:   mode_d = 3'b010;
                    2'b11:   mode_d = 3'b100;
                    default: mode_d = 3'b000;
                endcase
            end
        end

        if (err_c) begin
            frame_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    assign cmd_out    = cmd_out_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_seq    = cmd_seq_q;
    assign mode_power = mode_q[0];
    assign mode_save  = mode_q[1];
    assign mode_fetch = mode_q[2];
    assign ack_req    = ack_req_q;
    assign frame_err  = frame_err_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_cmd_frame_receiver.sv
// Directed bench for cmd_frame_receiver; expected output words are hand-computed.
module tb_cmd_frame_receiver;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       rx_en;
    logic [7:0] rx_data;
    logic       rx_pkt_done;
    logic [1:0] cmd_out;
    logic       cmd_valid;
    logic [7:0] cmd_seq;
    logic       mode_power, mode_save, mode_fetch;
    logic       ack_req;
    logic       ack_done;
    logic       frame_err;
    logic [7:0] err_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    cmd_frame_receiver dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .rx_en       (rx_en),
        .rx_data     (rx_data),
        .rx_pkt_done (rx_pkt_done),
        .cmd_out     (cmd_out),
        .cmd_valid   (cmd_valid),
        .cmd_seq     (cmd_seq),
        .mode_power  (mode_power),
        .mode_save   (mode_save),
        .mode_fetch  (mode_fetch),
        .ack_req     (ack_req),
        .ack_done    (ack_done),
        .frame_err   (frame_err),
        .err_cnt     (err_cnt)
    );

    always #10 sys_clk = ~sys_clk;

    // Packed view: {cmd_valid, cmd_out, cmd_seq, fetch, save, power, ack_req, frame_err, err_cnt}
    function automatic logic [23:0] status();
        return {cmd_valid, cmd_out, cmd_seq, mode_fetch, mode_save, mode_power,
                ack_req, frame_err, err_cnt};
    endfunction

    function automatic logic [23:0] mk(input logic cv, input logic [1:0] co, input logic [7:0] sq,
                                       input logic [2:0] md, input logic ak, input logic fe,
                                       input logic [7:0] ec);
        return {cv, co, sq, md, ak, fe, ec};
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        rx_en = 1'b1; rx_data = d; rx_pkt_done = last;
        tick();
        rx_en = 1'b0; rx_data = 8'h00; rx_pkt_done = 1'b0;
    endtask

    task automatic pkt_end();
        rx_pkt_done = 1'b1;
        tick();
        rx_pkt_done = 1'b0;
    endtask

    task automatic ack();
        ack_done = 1'b1;
        tick();
        ack_done = 1'b0;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        tick();
        tick();
        sys_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (status() !== mk(0, 0, 8'h00, 0, 0, 0, 0)) begin
            tests_failed++;
            $display("FAIL reset: got %h expected %h", status(), mk(0, 0, 8'h00, 0, 0, 0, 0));
        end
    endtask

    task automatic test_power();
        send(8'h5A, 0); send(8'h01, 0); send(8'h07, 0); send(8'h5C, 0);
        pkt_end();
        tests_run++;
        if (status() !== mk(1, 1, 8'h07, 3'b001, 1, 0, 0)) begin
            tests_failed++;
            $display("FAIL power_accept: got %h expected %h", status(), mk(1, 1, 8'h07, 3'b001, 1, 0, 0));
        end
        tick();
        tests_run++;
        if (status() !== mk(0, 1, 8'h07, 3'b001, 1, 0, 0)) begin
            tests_failed++;
            $display("FAIL power_strobe_len: got %h expected %h", status(), mk(0, 1, 8'h07, 3'b001, 1, 0, 0));
        end
        ack();
        tests_run++;
        if (status() !== mk(0, 1, 8'h07, 3'b001, 0, 0, 0)) begin
            tests_failed++;
            $display("FAIL ack_clear: got %h expected %h", status(), mk(0, 1, 8'h07, 3'b001, 0, 0, 0));
        end
    endtask

    task automatic test_back_to_back();
        send(8'h5A, 0); send(8'h03, 0); send(8'h08, 0); send(8'h51, 1);
        tests_run++;
        if (status() !== mk(1, 3, 8'h08, 3'b100, 1, 0, 0)) begin
            tests_failed++;
            $display("FAIL fetch_same_cycle_end: got %h expected %h", status(), mk(1, 3, 8'h08, 3'b100, 1, 0, 0));
        end
        send(8'h5A, 0); send(8'h00, 0); send(8'h09, 0); send(8'h53, 1);
        tests_run++;
        if (status() !== mk(1, 0, 8'h09, 3'b000, 1, 0, 0)) begin
            tests_failed++;
            $display("FAIL idle_while_ack_pending: got %h expected %h", status(), mk(1, 0, 8'h09, 3'b000, 1, 0, 0));
        end
        ack();
        tests_run++;
        if (status() !== mk(0, 0, 8'h09, 3'b000, 0, 0, 0)) begin
            tests_failed++;
            $display("FAIL single_ack_covers_two: got %h expected %h", status(), mk(0, 0, 8'h09, 3'b000, 0, 0, 0));
        end
    endtask

    task automatic test_errors();
        int n;
        send(8'h5A, 0); send(8'h02, 0); send(8'h0A, 0); send(8'h00, 1);
        tests_run++;
        if (status() !== mk(0, 0, 8'h09, 0, 0, 1, 8'd1)) begin
            tests_failed++;
            $display("FAIL bad_checksum: got %h expected %h", status(), mk(0, 0, 8'h09, 0, 0, 1, 8'd1));
        end
        tick();
        send(8'h5A, 0); send(8'h02, 0); send(8'h0B, 0); send(8'h53, 0); send(8'hFF, 1);
        tests_run++;
        if (status() !== mk(0, 0, 8'h09, 0, 0, 1, 8'd2)) begin
            tests_failed++;
            $display("FAIL long_frame: got %h expected %h", status(), mk(0, 0, 8'h09, 0, 0, 1, 8'd2));
        end
        tick();
        tests_run++;
        if (frame_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_strobe_len: got %b expected 0", frame_err);
        end
        send(8'h5A, 0); send(8'h02, 0);
        n = 0;
        for (int i = 1; i <= 50100; i++) begin
            tick();
            if (frame_err) begin
                n = i;
                break;
            end
        end
        tests_run++;
        if (n != 50000) begin
            tests_failed++;
            $display("FAIL timeout_cycle: got %0d expected 50000", n);
        end
        tests_run++;
        if (err_cnt !== 8'd3) begin
            tests_failed++;
            $display("FAIL timeout_count: got %0d expected 3", err_cnt);
        end
        tick();
        pkt_end();
        tests_run++;
        if (status() !== mk(0, 0, 8'h09, 0, 0, 0, 8'd3)) begin
            tests_failed++;
            $display("FAIL end_after_timeout: got %h expected %h", status(), mk(0, 0, 8'h09, 0, 0, 0, 8'd3));
        end
        send(8'h11, 1);
        tests_run++;
        if (status() !== mk(0, 0, 8'h09, 0, 0, 1, 8'd4)) begin
            tests_failed++;
            $display("FAIL bad_sync: got %h expected %h", status(), mk(0, 0, 8'h09, 0, 0, 1, 8'd4));
        end
        tick();
        send(8'h5A, 0); send(8'h01, 1);
        tests_run++;
        if (status() !== mk(0, 0, 8'h09, 0, 0, 1, 8'd5)) begin
            tests_failed++;
            $display("FAIL short_frame: got %h expected %h", status(), mk(0, 0, 8'h09, 0, 0, 1, 8'd5));
        end
        tick();
        pkt_end();
        tests_run++;
        if (frame_err !== 1'b0 || err_cnt !== 8'd5) begin
            tests_failed++;
            $display("FAIL empty_packet: got fe=%b cnt=%0d expected fe=0 cnt=5", frame_err, err_cnt);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 250; i++) begin
            send(8'h00, 1);
            tick();
        end
        tests_run++;
        if (err_cnt !== 8'd255) begin
            tests_failed++;
            $display("FAIL err_reach_255: got %0d expected 255", err_cnt);
        end
        send(8'h00, 1);
        tests_run++;
        if (frame_err !== 1'b1 || err_cnt !== 8'd255) begin
            tests_failed++;
            $display("FAIL err_saturate: got fe=%b cnt=%0d expected fe=1 cnt=255", frame_err, err_cnt);
        end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        send(8'h5A, 0); send(8'h01, 0);
        do_reset();
        tests_run++;
        if (status() !== mk(0, 0, 8'h00, 0, 0, 0, 0)) begin
            tests_failed++;
            $display("FAIL reset_mid_frame: got %h expected %h", status(), mk(0, 0, 8'h00, 0, 0, 0, 0));
        end
        pkt_end();
        tests_run++;
        if (frame_err !== 1'b0 || err_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL end_after_reset: got fe=%b cnt=%0d expected fe=0 cnt=0", frame_err, err_cnt);
        end
        send(8'h5A, 0); send(8'h01, 0); send(8'h07, 0); send(8'h5C, 1);
        tests_run++;
        if (status() !== mk(1, 1, 8'h07, 3'b001, 1, 0, 0)) begin
            tests_failed++;
            $display("FAIL accept_after_reset: got %h expected %h", status(), mk(1, 1, 8'h07, 3'b001, 1, 0, 0));
        end
        ack();
    endtask

    task automatic test_dup_filter();
        logic exp_cv;
`ifdef CMD_DUP_FILTER_EN
        exp_cv = 1'b0;
`else
        exp_cv = 1'b1;
`endif
        send(8'h5A, 0); send(8'h02, 0); send(8'h10, 0); send(8'h48, 1);
        tests_run++;
        if (status() !== mk(1, 2, 8'h10, 3'b010, 1, 0, 0)) begin
            tests_failed++;
            $display("FAIL dup_first: got %h expected %h", status(), mk(1, 2, 8'h10, 3'b010, 1, 0, 0));
        end
        ack();
        tests_run++;
        if (ack_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL dup_ack_clear: got %b expected 0", ack_req);
        end
        send(8'h5A, 0); send(8'h02, 0); send(8'h10, 0); send(8'h48, 1);
        tests_run++;
        if (status() !== mk(exp_cv, 2, 8'h10, 3'b010, 1, 0, 0)) begin
            tests_failed++;
            $display("FAIL dup_second: got %h expected %h", status(), mk(exp_cv, 2, 8'h10, 3'b010, 1, 0, 0));
        end
        ack();
    endtask

    initial begin
        sys_rst = 1'b1; rx_en = 1'b0; rx_data = 8'h00; rx_pkt_done = 1'b0; ack_done = 1'b0;
        test_reset();
        test_power();
        test_back_to_back();
        test_errors();
        test_saturate();
        test_reset_mid_frame();
        test_dup_filter();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
